fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Sequencer for the instruction-fetch stage: owns the architectural fetch PC and issues one-at-a-time word requests to instruction memory over a request/grant/rvalid handshake. It buffers returned instructions in a small FIFO toward decode and applies redirects from execute, discarding stale in-flight responses. It sits between the memory port and the decode pipeline register, replacing the fixed PC+4 combinational fetch path.

## Interface
- RESET_PC, 32'h8000_0000, first fetch address after reset
- FIFO_DEPTH, 2, instruction buffer entries (power of two, ≥2)

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- imem_o_req  out  1  fetch request valid
- imem_o_addr  out  32  fetch address, word-aligned
- imem_i_gnt  in  1  request accepted this cycle
- imem_i_rvalid  in  1  read data valid
- imem_i_rdata  in  32  instruction word
- redirect_i_valid  in  1  branch/jump redirect from execute
- redirect_i_pc  in  32  redirect target
- decode_o_valid  out  1  buffer head valid
- decode_o_instr  out  32  buffer head instruction
- decode_o_pc  out  32  PC of buffer head
- decode_i_ready  in  1  decode accepts head

## Operation
- States: S_IDLE, S_REQ, S_WAIT, S_FLUSH.
- S_IDLE: reset state. Moves to S_REQ on the first clock with rst_n=1.
- S_REQ: imem_o_req=1 only when count+outstanding < FIFO_DEPTH. On req&gnt: record outstanding PC, pc <= pc+4 (mod 2^32), go S_WAIT.
- S_WAIT: on rvalid, push {pc_out, rdata} into the FIFO and go S_REQ.
- S_FLUSH: outstanding response is stale. On rvalid, drop the data and go S_REQ.
- Redirect has highest priority in every state. It clears the FIFO, loads pc <= {redirect_i_pc[31:2],2'b00}, and blocks any push or pop that cycle. Next state:
  - from S_REQ with gnt that cycle: S_FLUSH, since the granted request is stale.
  - from S_WAIT without rvalid: S_FLUSH.
  - from S_WAIT with rvalid: S_REQ, response dropped.
  - in S_FLUSH without rvalid: stays S_FLUSH with the new pc.
  - in S_IDLE: pc is updated and state still moves to S_REQ.
- At most one outstanding memory transaction.
- Pop on decode_o_valid & decode_i_ready. Simultaneous push and pop is legal; count is unchanged.
- imem_o_addr = pc register in all states. It is undefined-safe but is only consumed when req=1.

## Timing
- Reset values:
  - imem_o_req=0, imem_o_addr=RESET_PC
  - decode_o_valid=0, decode_o_instr=32'h0000_0013 (NOP), decode_o_pc=0
  - FIFO empty, state S_IDLE
- Reset mid-operation drops the FIFO and any outstanding transaction without waiting for rvalid.
- imem_o_req is a decoded function of registered state and count. It has no combinational path from gnt, rvalid or redirect.
- Latency, zero-wait memory: req+gnt in cycle t, rvalid in t+1, decode_o_valid in t+2.
- Peak throughput: one instruction per 2 cycles.
- The first request asserts in the second cycle after rst_n rises.
- rvalid in S_REQ or S_IDLE is a protocol violation; it is ignored.
- When the FIFO is full, req stays low until a pop. The pop frees the slot in the same cycle and req rises the following cycle.
- When the FIFO is empty, decode_o_valid=0 and decode_o_instr holds NOP.

## Structure
- Package fetch_pkg holds:
  - state enum fetch_state_e
  - NOP_INSTR constant 32'h0000_0013
  - default RESET_PC
  - fetch_entry_t struct {pc[31:0], instr[31:0]}
- Sub-module fetch_fifo is synchronous, FIFO_DEPTH × fetch_entry_t, with push, pop, clear, count, valid and head outputs.
- FSM, PC register and outstanding-PC register live in fetch_ctrl.

## Test plan
- Reset release, gnt tied 1, rvalid one cycle after gnt, decode_i_ready=1:
  - addresses 0x8000_0000, 0x8000_0004 and 0x8000_0008 issue on alternate cycles.
  - first decode_o_valid appears 2 cycles after the first grant, with decode_o_pc=0x8000_0000.
- decode_i_ready=0 for 10 cycles: exactly FIFO_DEPTH instructions are buffered, req stays 0, and order is preserved on release.
- Redirect to 0x8000_0100 in S_WAIT, with rvalid 3 cycles later:
  - the stale word is dropped.
  - the next request address is 0x8000_0100.
  - decode sees nothing until that word returns.
- Redirect in the same cycle as rvalid, target 0x8000_0203: data dropped, next address 0x8000_0200, FIFO cleared.
- rst_n=0 for one cycle while in S_WAIT with 1 FIFO entry: next cycle all outputs hold reset values, and the late rvalid is ignored.
- PC wrap: redirect to 0xFFFF_FFFC, then the next sequential request address is 0x0000_0000.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch sequencer
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FLUSH
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam fetch_entry_t EMPTY_ENTRY = '{pc: 32'h0, instr: NOP_INSTR};

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous instruction buffer between the fetch FSM and decode
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  output logic [$clog2(DEPTH):0] count,
  output logic                   valid,
  output fetch_entry_t           head
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   mem_q [DEPTH];
  fetch_entry_t   mem_d [DEPTH];
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]    count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
    mem_q <= mem_d;
  end

  // Storage is never reset, so the head is masked to a NOP whenever empty.
  assign count = count_q;
  assign valid = (count_q != '0);
  assign head  = valid ? mem_q[rd_ptr_q] : EMPTY_ENTRY;

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch PC owner: one-outstanding imem requests, redirect flush, decode buffer
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_o_req,
  output logic [31:0] imem_o_addr,
  input  logic        imem_i_gnt,
  input  logic        imem_i_rvalid,
  input  logic [31:0] imem_i_rdata,
  input  logic        redirect_i_valid,
  input  logic [31:0] redirect_i_pc,
  output logic        decode_o_valid,
  output logic [31:0] decode_o_instr,
  output logic [31:0] decode_o_pc,
  input  logic        decode_i_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  out_pc_q, out_pc_d;

  logic         fifo_push, fifo_pop, fifo_clear, fifo_valid;
  logic [CW-1:0] fifo_count;
  fetch_entry_t fifo_head, push_entry;
  logic         granted;
  logic         unused_pc_lsb;

  // Nothing is ever outstanding in S_REQ, so free space is just depth minus count.
  assign imem_o_req    = (state_q == S_REQ) && (fifo_count < CW'(FIFO_DEPTH));
  assign imem_o_addr   = pc_q;
  assign granted       = imem_o_req & imem_i_gnt;
  assign push_entry    = '{pc: out_pc_q, instr: imem_i_rdata};
  assign unused_pc_lsb = ^redirect_i_pc[1:0];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    out_pc_d   = out_pc_q;
    fifo_push  = 1'b0;
    fifo_pop   = fifo_valid & decode_i_ready & ~redirect_i_valid;
    fifo_clear = redirect_i_valid;

    case (state_q)
      S_IDLE:  state_d = S_REQ;
      S_REQ: begin
        if (granted) begin
          out_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_i_rvalid) begin
          fifo_push = 1'b1;
          state_d   = S_REQ;
        end
      end
      S_FLUSH: begin
        if (imem_i_rvalid) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A redirect overrides the normal step; any response still owed becomes stale.
    if (redirect_i_valid) begin
      pc_d      = {redirect_i_pc[31:2], 2'b00};
      fifo_push = 1'b0;
      case (state_q)
        S_REQ:           state_d = granted ? S_FLUSH : S_REQ;
        S_WAIT, S_FLUSH: state_d = imem_i_rvalid ? S_REQ : S_FLUSH;
        default:         state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      out_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      out_pc_q <= out_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (fifo_clear),
    .push     (fifo_push),
    .push_data(push_entry),
    .pop      (fifo_pop),
    .count    (fifo_count),
    .valid    (fifo_valid),
    .head     (fifo_head)
  );

  assign decode_o_valid = fifo_valid;
  assign decode_o_instr = fifo_head.instr;
  assign decode_o_pc    = fifo_head.pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - scoreboard bench for fetch_ctrl with a randomized memory/decode/redirect environment
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC   = 32'h8000_0000;
  localparam int          FIFO_DEPTH = 2;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_o_req;
  logic [31:0] imem_o_addr;
  logic        imem_i_gnt;
  logic        imem_i_rvalid;
  logic [31:0] imem_i_rdata;
  logic        redirect_i_valid;
  logic [31:0] redirect_i_pc;
  logic        decode_o_valid;
  logic [31:0] decode_o_instr;
  logic [31:0] decode_o_pc;
  logic        decode_i_ready;

  fetch_ctrl #(
    .RESET_PC  (RESET_PC),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_o_req      (imem_o_req),
    .imem_o_addr     (imem_o_addr),
    .imem_i_gnt      (imem_i_gnt),
    .imem_i_rvalid   (imem_i_rvalid),
    .imem_i_rdata    (imem_i_rdata),
    .redirect_i_valid(redirect_i_valid),
    .redirect_i_pc   (redirect_i_pc),
    .decode_o_valid  (decode_o_valid),
    .decode_o_instr  (decode_o_instr),
    .decode_o_pc     (decode_o_pc),
    .decode_i_ready  (decode_i_ready)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] model_pc = RESET_PC;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          n_pops = 0;
  int          grant_cyc[$];
  logic [31:0] grant_addr[$];
  int          first_valid_cyc = -1;
  logic [31:0] first_valid_pc = '0;

  int          gnt_pct = 100;
  int          rdy_pct = 100;
  int          lat_min = 0;
  int          lat_max = 0;
  bit          rand_redir = 0;
  bit          force_redir = 0;
  bit          redir_on_rvalid = 0;
  logic [31:0] redir_target = '0;

  bit          pend = 0;
  logic [31:0] pend_addr = '0;
  int          lat = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_req"},   {31'b0, imem_o_req},     32'd0);
    check({tag, "_addr"},  imem_o_addr,             RESET_PC);
    check({tag, "_valid"}, {31'b0, decode_o_valid}, 32'd0);
    check({tag, "_instr"}, decode_o_instr,          NOP);
    check({tag, "_pc"},    decode_o_pc,             32'd0);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Memory, decode and redirect driver: one transaction at a time, configurable latency.
  initial begin
    imem_i_gnt       = 1'b0;
    imem_i_rvalid    = 1'b0;
    imem_i_rdata     = '0;
    redirect_i_valid = 1'b0;
    redirect_i_pc    = '0;
    decode_i_ready   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      imem_i_rvalid    = 1'b0;
      redirect_i_valid = 1'b0;
      if (pend) begin
        if (lat == 0) begin
          imem_i_rvalid = 1'b1;
          imem_i_rdata  = mem_word(pend_addr);
          pend          = 0;
          if (redir_on_rvalid) begin
            redirect_i_valid = 1'b1;
            redirect_i_pc    = redir_target;
            redir_on_rvalid  = 0;
          end
        end else begin
          lat = lat - 1;
        end
      end
      if (force_redir) begin
        redirect_i_valid = 1'b1;
        redirect_i_pc    = redir_target;
        force_redir      = 0;
      end else if (rand_redir && $urandom_range(0, 99) < 4) begin
        redirect_i_valid = 1'b1;
        redirect_i_pc    = $urandom;
      end
      imem_i_gnt     = ($urandom_range(0, 99) < gnt_pct);
      decode_i_ready = ($urandom_range(0, 99) < rdy_pct);
      @(negedge clk);
      if (rst_n && imem_o_req && imem_i_gnt) begin
        pend      = 1;
        pend_addr = imem_o_addr;
        lat       = $urandom_range(lat_min, lat_max);
      end
    end
  end

  // Reference model: fetch addresses run sequentially from the last redirect target;
  // every non-stale grant owes decode one {pc, mem[pc]} entry, in order; a redirect voids all owed entries.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sbq.delete();
        model_pc = RESET_PC;
      end else begin
        if (imem_o_req) check("req_room", {31'b0, sbq.size() < FIFO_DEPTH}, 32'd1);
        if (imem_o_req && imem_i_gnt) begin
          check("req_addr", imem_o_addr, model_pc);
          if (!redirect_i_valid) begin
            sbq.push_back('{pc: model_pc, instr: mem_word(model_pc)});
            grant_cyc.push_back(cyc);
            grant_addr.push_back(imem_o_addr);
          end
          model_pc = model_pc + 32'd4;
        end
        if (decode_o_valid && first_valid_cyc < 0) begin
          first_valid_cyc = cyc;
          first_valid_pc  = decode_o_pc;
        end
        if (decode_o_valid && decode_i_ready && !redirect_i_valid) begin
          n_pops++;
          if (sbq.size() == 0) begin
            check("pop_unexpected", {31'b0, decode_o_valid}, 32'd0);
          end else begin
            exp_t e;
            e = sbq.pop_front();
            check("pop_pc", decode_o_pc, e.pc);
            check("pop_instr", decode_o_instr, e.instr);
          end
        end
        if (!decode_o_valid) check("empty_nop", decode_o_instr, NOP);
        if (redirect_i_valid) begin
          sbq.delete();
          model_pc = {redirect_i_pc[31:2], 2'b00};
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int rel_cyc;
    int pops0;
    rst_n = 1'b0;

    // Reset state and startup latency with an always-granting zero-wait memory.
    repeat (3) tick();
    reset_checks("rst");
    grant_cyc.delete();
    grant_addr.delete();
    first_valid_cyc = -1;
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    rel_cyc = cyc;
    n = 0;
    while ((grant_addr.size() < 3 || first_valid_cyc < 0) && n < 40) begin
      tick();
      n++;
    end
    check("t1_grants_seen", {31'b0, grant_addr.size() >= 3}, 32'd1);
    if (grant_addr.size() >= 3) begin
      check("t1_first_req_cycle", grant_cyc[0] - rel_cyc, 32'd1);
      check("t1_addr0", grant_addr[0], 32'h8000_0000);
      check("t1_addr1", grant_addr[1], 32'h8000_0004);
      check("t1_addr2", grant_addr[2], 32'h8000_0008);
      check("t1_gap01", grant_cyc[1] - grant_cyc[0], 32'd2);
      check("t1_gap12", grant_cyc[2] - grant_cyc[1], 32'd2);
      check("t1_first_valid_lat", first_valid_cyc - grant_cyc[0], 32'd2);
      check("t1_first_valid_pc", first_valid_pc, 32'h8000_0000);
    end

    // Decode stall: buffer fills, requests stop, then drains exactly FIFO_DEPTH entries.
    rdy_pct = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i >= 5) begin
        check("stall_req_low", {31'b0, imem_o_req}, 32'd0);
        check("stall_valid", {31'b0, decode_o_valid}, 32'd1);
      end
    end
    rdy_pct = 100;
    gnt_pct = 0;
    pops0   = n_pops;
    tick();
    tick();
    check("stall_req_rises", {31'b0, imem_o_req}, 32'd1);
    repeat (6) tick();
    check("stall_drain_count", n_pops - pops0, FIFO_DEPTH);

    // Redirect while a response is outstanding; the stale word arrives three cycles later.
    gnt_pct = 100;
    lat_min = 3;
    lat_max = 3;
    n = 0;
    while (!pend && n < 20) begin
      tick();
      n++;
    end
    check("rw_pend_seen", {31'b0, pend}, 32'd1);
    redir_target = 32'h8000_0100;
    force_redir  = 1;
    tick();
    grant_addr.delete();
    n = 0;
    while (grant_addr.size() < 1 && n < 20) begin
      tick();
      check("rw_decode_quiet", {31'b0, decode_o_valid}, 32'd0);
      n++;
    end
    check("rw_regrant_seen", {31'b0, grant_addr.size() >= 1}, 32'd1);
    if (grant_addr.size() >= 1) check("rw_next_addr", grant_addr[0], 32'h8000_0100);

    // Redirect coinciding with rvalid while one entry is buffered.
    lat_min = 0;
    lat_max = 0;
    rdy_pct = 0;
    n = 0;
    while (!decode_o_valid && n < 30) begin
      tick();
      n++;
    end
    check("rv_buffered", {31'b0, decode_o_valid}, 32'd1);
    redir_target    = 32'h8000_0203;
    redir_on_rvalid = 1;
    grant_addr.delete();
    tick();
    tick();
    check("rv_fifo_cleared", {31'b0, decode_o_valid}, 32'd0);
    n = 0;
    while (grant_addr.size() < 1 && n < 20) begin
      tick();
      n++;
    end
    check("rv_regrant_seen", {31'b0, grant_addr.size() >= 1}, 32'd1);
    if (grant_addr.size() >= 1) check("rv_next_addr", grant_addr[0], 32'h8000_0200);

    // Reset pulse in S_WAIT with one buffered entry; the late rvalid lands in S_IDLE.
    gnt_pct = 0;
    rdy_pct = 100;
    repeat (8) tick();
    rdy_pct = 0;
    gnt_pct = 100;
    lat_min = 1;
    lat_max = 1;
    n = 0;
    while (!(decode_o_valid && pend) && n < 30) begin
      tick();
      n++;
    end
    check("rst_mid_setup", {31'b0, decode_o_valid && pend}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    reset_checks("rst_mid");
    rdy_pct = 100;
    lat_min = 0;
    lat_max = 0;
    repeat (12) tick();

    // PC wrap across the top of the address space.
    redir_target = 32'hFFFF_FFFC;
    force_redir  = 1;
    tick();
    grant_addr.delete();
    n = 0;
    while (grant_addr.size() < 2 && n < 30) begin
      tick();
      n++;
    end
    check("wrap_grants_seen", {31'b0, grant_addr.size() >= 2}, 32'd1);
    if (grant_addr.size() >= 2) begin
      check("wrap_addr0", grant_addr[0], 32'hFFFF_FFFC);
      check("wrap_addr1", grant_addr[1], 32'h0000_0000);
    end

    // Randomized traffic: sporadic grants, variable latency, back-pressure and redirects.
    gnt_pct    = 70;
    rdy_pct    = 70;
    lat_min    = 0;
    lat_max    = 3;
    rand_redir = 1;
    repeat (1500) tick();
    rand_redir = 0;
    gnt_pct    = 0;
    rdy_pct    = 100;
    repeat (20) tick();
    check("drain_all_delivered", sbq.size(), 32'd0);
    check("drain_valid_low", {31'b0, decode_o_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
